mm2_stage: RTL
==============

Name: mm2_stage

Overview:
- Second memory stage of the in-order pipeline; sits directly upstream of the MM2/WB pipeline register and drives its mm2_* inputs.
- Latches instructions from MM1 and waits for the data SRAM response (data_ok) of loads/stores issued in MM1.
- Aligns and sign/zero-extends load data, then hands a completed instruction to WB via valid/allowin handshake.
- Tracks responses orphaned by flush so they are discarded, never attributed to a younger instruction.

Parameters:
DISCARD_W, 2, width of orphaned-response counter; max outstanding discards = 2^DISCARD_W-1

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
flush  in  1  kill in-flight instruction (exception/ertn)
mm1_to_mm2_valid  in  1  MM1 presents an instruction
mm2_allowin  out  1  stage can accept from MM1 this cycle
in_is_load  in  1  load instruction
in_is_store  in  1  store instruction
in_unsigned  in  1  zero-extend load (ld.bu/ld.hu)
in_mm_access_sz  in  2  0=byte 1=half 2=word
in_exe_out  in  32  ALU result / effective address
in_reg_d  in  5  destination register
in_reg_d_wen  in  1  destination write enable
in_pc  in  32  instruction PC
data_sram_data_ok  in  1  memory response valid, one pulse per accepted request
data_sram_rdata  in  32  memory read data
wb_allowin  in  1  WB register accepts this cycle
mm2_to_wb_valid  out  1  completed instruction present
mm2_exe_out  out  32  latched in_exe_out
mm2_rdata  out  32  aligned/extended load data; 0 for non-loads
mm2_reg_d  out  5  latched in_reg_d
mm2_reg_d_wen  out  1  in_reg_d_wen AND mm2_to_wb_valid
mm2_mm_access_sz  out  2  latched in_mm_access_sz
mm2_pc  out  32  latched in_pc

Behaviour:
- Reset (rst=1 at posedge): state=EMPTY, discard_cnt=0, all payload regs and all outputs 0; mm2_allowin=1 after reset unless discard_cnt at max.
- States: EMPTY, WAIT (mem op awaiting data_ok), DONE (result ready for WB).
- Accept: mm1_to_mm2_valid && mm2_allowin && !flush latches payload at posedge; load/store -> WAIT, otherwise -> DONE.
- Every load/store reaching MM2 has its request already accepted in MM1 (MM1 forwards only after addr_ok).
- mm2_allowin = (state==EMPTY || (state==DONE && wb_allowin)) && discard_cnt != max.
- WAIT: data_ok with discard_cnt==0 -> capture response -> DONE next cycle (1-cycle latency from data_ok to mm2_to_wb_valid). data_ok with discard_cnt>0 -> discard_cnt-1, stay WAIT, data ignored.
- Load data: shift = in_exe_out[1:0]*8; byte = rdata>>shift [7:0], half = rdata>>shift [15:0], word = rdata; sign-extend from bit 7/15 unless in_unsigned. Misaligned accesses do not reach this stage. Stores: mm2_rdata=0.
- DONE: mm2_to_wb_valid=1; leaves on wb_allowin: -> new instruction's state if accepted same cycle, else EMPTY.
- EMPTY: mm2_to_wb_valid=0, mm2_reg_d_wen=0.
- Flush (highest priority): state -> EMPTY, no accept that cycle. If state==WAIT and no data_ok that cycle, discard_cnt+1. If WAIT with data_ok the same cycle, response is consumed (dropped) and discard_cnt is unchanged. Flush in DONE/EMPTY leaves discard_cnt unchanged.
- data_ok while EMPTY/DONE with discard_cnt>0: decrement. With discard_cnt==0 the response is spurious and ignored (assertion in bench).
- discard_cnt never wraps; the allowin gating guarantees it.
- Reset mid-WAIT clears state and counter; the memory side is reset concurrently.

Test Plan:
- ld.b at addr ...2, rdata=0x12_80_34_56, data_ok 3 cycles after accept -> mm2_rdata=0xFFFFFF80, valid exactly 1 cycle after data_ok.
- ld.hu at addr ...2, rdata=0x8001_xxxx -> mm2_rdata=0x00008001; ld.w -> rdata unchanged; st.w -> mm2_rdata=0, valid after data_ok.
- ALU op with wb_allowin=0 for 4 cycles -> valid held, mm2_allowin=0, payload stable; released -> back-to-back accept in the same cycle.
- Flush while load in WAIT (no data_ok) -> discard_cnt=1; next load accepted; first data_ok (0xDEAD) dropped, second (0x55) -> mm2_rdata=0x55.
- Flush coincident with data_ok in WAIT -> discard_cnt stays 0, valid never asserted.
- Three consecutive flushed WAIT loads (DISCARD_W=2) -> discard_cnt=3, mm2_allowin=0 until one data_ok arrives.

Source files
------------

// File: rtl/mm2_stage.sv
// Second memory stage: holds one instruction from MM1, waits for its data SRAM
// response, aligns load data and hands the result to WB. Orphaned responses are counted and dropped.
//
// state   | meaning
// --------+-----------------------------------------------
// S_EMPTY | no instruction held
// S_WAIT  | load/store held, awaiting its data_ok
// S_DONE  | result ready, presented to WB
module mm2_stage #(
    parameter int DISCARD_W = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        mm1_to_mm2_valid,
    output logic        mm2_allowin,
    input  logic        in_is_load,
    input  logic        in_is_store,
    input  logic        in_unsigned,
    input  logic [1:0]  in_mm_access_sz,
    input  logic [31:0] in_exe_out,
    input  logic [4:0]  in_reg_d,
    input  logic        in_reg_d_wen,
    input  logic [31:0] in_pc,
    input  logic        data_sram_data_ok,
    input  logic [31:0] data_sram_rdata,
    input  logic        wb_allowin,
    output logic        mm2_to_wb_valid,
    output logic [31:0] mm2_exe_out,
    output logic [31:0] mm2_rdata,
    output logic [4:0]  mm2_reg_d,
    output logic        mm2_reg_d_wen,
    output logic [1:0]  mm2_mm_access_sz,
    output logic [31:0] mm2_pc
);

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_WAIT  = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    localparam logic [DISCARD_W-1:0] DISCARD_MAX = '1;
    localparam logic [DISCARD_W-1:0] DISCARD_ONE = DISCARD_W'(1);

    state_t               state_q, state_d;
    logic [DISCARD_W-1:0] discard_q, discard_d;
    logic [31:0]          exe_out_q;
    logic [31:0]          pc_q;
    logic [31:0]          rdata_q;
    logic [4:0]           reg_d_q;
    logic                 reg_d_wen_q;
    logic [1:0]           sz_q;
    logic                 is_load_q;
    logic                 unsigned_q;

    logic        accept;
    logic        in_is_mem;
    logic        resp_ours;
    logic [31:0] shifted;
    logic [31:0] load_data;

    assign in_is_mem   = in_is_load | in_is_store;
    assign mm2_allowin = ((state_q == S_EMPTY) || ((state_q == S_DONE) && wb_allowin))
                         && (discard_q != DISCARD_MAX);
    assign accept      = mm1_to_mm2_valid && mm2_allowin && !flush;
    // Responses are in order, so any pending orphan owns the current data_ok.
    assign resp_ours   = (state_q == S_WAIT) && data_sram_data_ok && (discard_q == '0);

    assign shifted = data_sram_rdata >> {exe_out_q[1:0], 3'b000};

    always_comb begin
        load_data = data_sram_rdata;
        case (sz_q)
            2'd0:    load_data = {{24{~unsigned_q & shifted[7]}}, shifted[7:0]};
            2'd1:    load_data = {{16{~unsigned_q & shifted[15]}}, shifted[15:0]};
            default: load_data = data_sram_rdata;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        discard_d = discard_q;
        if (flush) begin
            state_d = S_EMPTY;
            // A flushed WAIT with a same-cycle response nets to no change.
            if (state_q == S_WAIT) begin
                if (!data_sram_data_ok) begin
                    discard_d = discard_q + DISCARD_ONE;
                end
            end else if (data_sram_data_ok && (discard_q != '0)) begin
                discard_d = discard_q - DISCARD_ONE;
            end
        end else begin
            if (data_sram_data_ok && (discard_q != '0)) begin
                discard_d = discard_q - DISCARD_ONE;
            end
            case (state_q)
                S_EMPTY: begin
                    if (accept) begin
                        state_d = in_is_mem ? S_WAIT : S_DONE;
                    end
                end
                S_WAIT: begin
                    if (resp_ours) begin
                        state_d = S_DONE;
                    end
                end
                S_DONE: begin
                    if (wb_allowin) begin
                        if (accept) begin
                            state_d = in_is_mem ? S_WAIT : S_DONE;
                        end else begin
                            state_d = S_EMPTY;
                        end
                    end
                end
                default: state_d = S_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_EMPTY;
            discard_q   <= '0;
            exe_out_q   <= '0;
            pc_q        <= '0;
            rdata_q     <= '0;
            reg_d_q     <= '0;
            reg_d_wen_q <= 1'b0;
            sz_q        <= '0;
            is_load_q   <= 1'b0;
            unsigned_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            discard_q <= discard_d;
            if (accept) begin
                exe_out_q   <= in_exe_out;
                pc_q        <= in_pc;
                rdata_q     <= '0;
                reg_d_q     <= in_reg_d;
                reg_d_wen_q <= in_reg_d_wen;
                sz_q        <= in_mm_access_sz;
                is_load_q   <= in_is_load;
                unsigned_q  <= in_unsigned;
            end else if (resp_ours && !flush) begin
                rdata_q <= is_load_q ? load_data : '0;
            end
        end
    end

    assign mm2_to_wb_valid  = (state_q == S_DONE);
    assign mm2_exe_out      = exe_out_q;
    assign mm2_rdata        = rdata_q;
    assign mm2_reg_d        = reg_d_q;
    assign mm2_reg_d_wen    = reg_d_wen_q & (state_q == S_DONE);
    assign mm2_mm_access_sz = sz_q;
    assign mm2_pc           = pc_q;

endmodule
